tone_contour_gen: RTL and testbench
===================================

// Module: tone_contour_gen
// PURPOSE
//  Synthesises a 4-segment pitch contour for a 3-bit tone_ident code.
//  Codes: 000 neutral, 001 rising, 010 undulating, 100 falling.
//  Output is a square-wave sample stream for the DAC/PWM path, used as a loop-back stimulus for tone_detection_fsm.
//  Each segment step is 25% of base pitch, above the detector's 20% significance threshold.
// PARAMETERS
//  PHASE_W            24        phase accumulator / increment width
//  SAMPLE_W           16        signed output sample width
//  BASE_INC           24'h100000 phase increment of the base pitch (must satisfy BASE_INC*7/4 < 2**(PHASE_W-1))
//  CYCLES_PER_SAMPLE  2272      clk_in cycles per output sample (>=2)
//  SEGMENT_SAMPLES    4096      samples per contour segment (>=1)
//  AMPLITUDE          16'sd8192 output magnitude, positive, < 2**(SAMPLE_W-1)
// PORTS
//  clk_in           in   1         system clock
//  rst_in           in   1         asynchronous, active-low reset
//  tone_ident_in    in   3         requested contour code
//  valid_in         in   1         request strobe
//  ready_out        out  1         high when a request can be accepted
//  sample_out       out  SAMPLE_W  signed sample, held between strobes
//  sample_valid_out out  1         1-cycle strobe per new sample
//  busy_out         out  1         high while playing
//  done_out         out  1         1-cycle pulse with the final sample
//  err_out          out  1         1-cycle pulse when an illegal code is accepted
// BEHAVIOUR
//  Reset (rst_in=0, async): state IDLE, ready_out=1, all other outputs 0, all counters/accumulator 0. Takes effect mid-play immediately, with no final sample or done pulse.
//  Handshake: a request is accepted on the clk_in edge with valid_in && ready_out. ready_out=1 only in IDLE. valid_in outside IDLE is ignored, not queued.
//  Legal codes: tone_ident_in is latched and the FSM goes to PLAY. Phase, tick, sample and segment counters clear to 0.
//  Illegal codes (any other): err_out pulses the cycle after acceptance; the FSM stays in IDLE and ready_out stays 1.
//  FSM states:
//   IDLE -> PLAY on a legal accept
//   PLAY -> IDLE on the final sample
//   No other states.
//  Increment per segment s=0..3, with step = BASE_INC>>2:
//   neutral:    B, B, B, B
//   rising:     B, B+step, B+2step, B+3step
//   falling:    B+3step, B+2step, B+step, B
//   undulating: B, B+step, B+2step, B+step
//   Computed with shifts and adds only; no multiplier or divider.
//  Timing in PLAY:
//   - tick counts 0..CYCLES_PER_SAMPLE-1 and wraps.
//   - On tick==CYCLES_PER_SAMPLE-1: phase += inc(seg), modulo 2**PHASE_W.
//   - On the same tick, sample_out = new phase MSB ? -AMPLITUDE : +AMPLITUDE, and sample_valid_out=1 for 1 cycle.
//   - The first strobe occurs CYCLES_PER_SAMPLE cycles after the accept edge.
//  Segment/sample counters:
//   - The sample counter wraps at SEGMENT_SAMPLES-1, then seg increments.
//   - The 4*SEGMENT_SAMPLES-th strobe coincides with done_out=1.
//   - The next edge enters IDLE: ready_out=1, busy_out=0, and sample_out returns to 0.
//  Simultaneous valid_in with done_out: ignored, because ready_out is still 0 that cycle.
//  busy_out = (state==PLAY). sample_out is 0 in IDLE.
// STRUCTURE
//  tone_pkg (shared with tone_detection_fsm):
//   - TONE_NEUTRAL / TONE_RISING / TONE_UNDULATING / TONE_FALLING localparams
//   - gen_state_t enum {IDLE, PLAY}
//   - segment step multiplier table
//  Sub-module phase_accum_osc (PHASE_W, SAMPLE_W, AMPLITUDE):
//   - Ports: clear, step strobe, inc in -> sample out.
//   - Holds the accumulator and the MSB->sample mapping.
//  Top-level file: FSM, tick/sample/segment counters, increment mux, handshake.
// TESTING (PHASE_W=24, BASE_INC=24'h100000, CYCLES_PER_SAMPLE=4, SEGMENT_SAMPLES=8, AMPLITUDE=8192)
//  1. Reset -> ready_out=1, busy/done/err/sample_valid=0, sample_out=0.
//     Assert rst_in=0 mid-play -> same values on the same cycle.
//  2. Accept 001 rising -> 32 strobes, 4 cycles apart, first strobe 4 cycles after accept.
//     Per-segment phase deltas 0x100000, 0x140000, 0x180000, 0x1C0000.
//     done_out on strobe 32 (128 cycles after accept); ready_out=1 next cycle.
//  3. Accept 000 neutral -> strobes 1..7 = +8192, strobe 8 = -8192 (phase 0x800000).
//     All 32 phase deltas equal 0x100000.
//  4. Accept 100 falling, then 010 undulating -> deltas 0x1C0000, 0x180000, 0x140000, 0x100000,
//     then 0x100000, 0x140000, 0x180000, 0x140000.
//  5. Accept 011 illegal -> err_out pulse 1 cycle later, no strobes, ready_out stays 1.
//  6. Hold valid_in=1 with alternating codes through a playback, including the done_out cycle
//     -> only the IDLE-time request is accepted; second playback starts after ready_out returns high.

Source files
------------

// File: rtl/tone_contour_gen_pkg.sv
// Shared tone codes, generator state encoding and per-segment pitch-step table
// for the contour generator and its loop-back partner detector.
package tone_contour_gen_pkg;

  localparam logic [2:0] TONE_NEUTRAL    = 3'b000;
  localparam logic [2:0] TONE_RISING     = 3'b001;
  localparam logic [2:0] TONE_UNDULATING = 3'b010;
  localparam logic [2:0] TONE_FALLING    = 3'b100;

  typedef logic [0:0] gen_state_t;
  localparam gen_state_t StIdle = 1'b0;
  localparam gen_state_t StPlay = 1'b1;

  // Step multipliers packed {seg3, seg2, seg1, seg0}, two bits each.
  localparam logic [7:0] MULT_NEUTRAL    = 8'b00_00_00_00;
  localparam logic [7:0] MULT_RISING     = 8'b11_10_01_00;
  localparam logic [7:0] MULT_FALLING    = 8'b00_01_10_11;
  localparam logic [7:0] MULT_UNDULATING = 8'b01_10_01_00;

  function automatic logic is_legal(logic [2:0] code);
    logic ok;
    case (code)
      TONE_NEUTRAL, TONE_RISING, TONE_UNDULATING, TONE_FALLING: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] seg_mult(logic [2:0] code, logic [1:0] seg);
    logic [7:0] tbl;
    case (code)
      TONE_RISING:     tbl = MULT_RISING;
      TONE_FALLING:    tbl = MULT_FALLING;
      TONE_UNDULATING: tbl = MULT_UNDULATING;
      default:         tbl = MULT_NEUTRAL;
    endcase
    return tbl[{seg, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/tone_contour_gen_if.sv
// Request/sample-stream bundle between a requester and the contour generator.
interface tone_contour_gen_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic [2:0]                 tone_ident_in;
  logic                       valid_in;
  logic                       ready_out;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid_out;
  logic                       busy_out;
  logic                       done_out;
  logic                       err_out;

  modport master (
    output tone_ident_in, valid_in,
    input  ready_out, sample_out, sample_valid_out, busy_out, done_out, err_out
  );

  modport slave (
    input  tone_ident_in, valid_in,
    output ready_out, sample_out, sample_valid_out, busy_out, done_out, err_out
  );
endinterface

// File: rtl/tone_contour_gen_phase_accum_osc.sv
// Phase accumulator with square-wave output: sample sign follows the phase MSB
// after each step; clear zeroes both the phase and the held sample.
module tone_contour_gen_phase_accum_osc #(
  parameter int unsigned                PHASE_W   = 24,
  parameter int unsigned                SAMPLE_W  = 16,
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = 16'sd8192
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clear,
  input  logic                       step,
  input  logic [PHASE_W-1:0]         inc,
  output logic signed [SAMPLE_W-1:0] sample
);

  localparam logic signed [SAMPLE_W-1:0] NegAmp = -AMPLITUDE;

  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;

  always_comb begin
    phase_d  = phase_q;
    sample_d = sample_q;
    if (clear) begin
      phase_d  = '0;
      sample_d = '0;
    end else if (step) begin
      phase_d  = phase_q + inc;
      sample_d = phase_d[PHASE_W-1] ? NegAmp : AMPLITUDE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_q  <= '0;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/tone_contour_gen.sv
// Four-segment pitch-contour generator: handshake, IDLE/PLAY control, sample and
// segment timing, and per-segment phase-increment selection feeding the oscillator.
module tone_contour_gen
  import tone_contour_gen_pkg::*;
#(
  parameter int unsigned                PHASE_W           = 24,
  parameter int unsigned                SAMPLE_W          = 16,
  parameter logic [PHASE_W-1:0]         BASE_INC          = 24'h100000,
  parameter int unsigned                CYCLES_PER_SAMPLE = 2272,
  parameter int unsigned                SEGMENT_SAMPLES   = 4096,
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE         = 16'sd8192
) (
  input logic               clk_in,
  input logic               rst_in,
  tone_contour_gen_if.slave bus
);

  localparam int unsigned TickW = $clog2(CYCLES_PER_SAMPLE);
  localparam int unsigned SmpW  = (SEGMENT_SAMPLES > 1) ? $clog2(SEGMENT_SAMPLES) : 1;
  localparam logic [PHASE_W-1:0] Step = BASE_INC >> 2;

  gen_state_t       state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [SmpW-1:0]  smp_q, smp_d;
  logic [1:0]       seg_q, seg_d;
  logic             sv_q, done_q, err_q;

  logic                       ready, accept, legal, tick_last, smp_last, strobe, last;
  logic [1:0]                 mult;
  logic [PHASE_W-1:0]         inc;
  logic signed [SAMPLE_W-1:0] osc_sample;

  assign ready     = (state_q == StIdle);
  assign accept    = bus.valid_in && ready;
  assign legal     = is_legal(bus.tone_ident_in);
  assign tick_last = (tick_q == TickW'(CYCLES_PER_SAMPLE - 1));
  assign smp_last  = (smp_q == SmpW'(SEGMENT_SAMPLES - 1));
  // done_q gates the strobe so the tail cycle before IDLE can never emit a sample.
  assign strobe    = (state_q == StPlay) && !done_q && tick_last;
  assign last      = strobe && smp_last && (seg_q == 2'd3);

  // B + mult*step, with mult in 0..3 built from two shifted adds.
  assign mult = seg_mult(code_q, seg_q);
  assign inc  = BASE_INC + (mult[0] ? Step : '0) + (mult[1] ? (Step << 1) : '0);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tick_d  = tick_q;
    smp_d   = smp_q;
    seg_d   = seg_q;
    case (state_q)
      StIdle: begin
        if (accept && legal) begin
          state_d = StPlay;
          code_d  = bus.tone_ident_in;
          tick_d  = '0;
          smp_d   = '0;
          seg_d   = '0;
        end
      end
      StPlay: begin
        if (done_q) begin
          state_d = StIdle;
        end else begin
          tick_d = tick_last ? '0 : tick_q + TickW'(1);
          if (tick_last) begin
            if (smp_last) begin
              smp_d = '0;
              seg_d = seg_q + 2'd1;
            end else begin
              smp_d = smp_q + SmpW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      code_q  <= '0;
      tick_q  <= '0;
      smp_q   <= '0;
      seg_q   <= '0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
      smp_q   <= smp_d;
      seg_q   <= seg_d;
      sv_q    <= strobe;
      done_q  <= last;
      err_q   <= accept && !legal;
    end
  end

  tone_contour_gen_phase_accum_osc #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W),
    .AMPLITUDE(AMPLITUDE)
  ) u_osc (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clear (accept && legal),
    .step  (strobe),
    .inc   (inc),
    .sample(osc_sample)
  );

  assign bus.ready_out        = ready;
  assign bus.busy_out         = (state_q == StPlay);
  assign bus.sample_out       = (state_q == StPlay) ? osc_sample : '0;
  assign bus.sample_valid_out = sv_q;
  assign bus.done_out         = done_q;
  assign bus.err_out          = err_q;

endmodule

// File: tb/tb_tone_contour_gen.sv
// Directed bench for tone_contour_gen with small timing parameters: table of
// codes with expected step multipliers, plus reset and held-valid sequences.
module tb_tone_contour_gen;

  localparam logic [23:0] Base = 24'h100000;
  localparam logic [23:0] Stp  = 24'h040000;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_in = ~clk_in;

  tone_contour_gen_if #(.SAMPLE_W(16)) bus ();

  tone_contour_gen #(
    .PHASE_W          (24),
    .SAMPLE_W         (16),
    .BASE_INC         (24'h100000),
    .CYCLES_PER_SAMPLE(4),
    .SEGMENT_SAMPLES  (8),
    .AMPLITUDE        (16'sd8192)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  typedef struct {
    string            name;
    logic [2:0]       code;
    bit               legal;
    logic [3:0][1:0]  mult;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bus.ready_out), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
    check({tag, "_done"}, 32'(bus.done_out), 32'd0);
    check({tag, "_err"}, 32'(bus.err_out), 32'd0);
    check({tag, "_sv"}, 32'(bus.sample_valid_out), 32'd0);
    check({tag, "_sample"}, bus.sample_out, 32'd0);
  endtask

  // Runs from just after the accept edge through the first IDLE cycle.
  task automatic play_body(input string tag, input logic [3:0][1:0] mult, input bit hold);
    logic [23:0]        ph  = '0;
    logic signed [15:0] smp = '0;
    logic [2:0]         alt [4] = '{3'b000, 3'b100, 3'b011, 3'b010};
    int                 n   = 0;
    bit                 exp_sv;
    for (int k = 1; k <= 129; k++) begin
      @(posedge clk_in);
      #1;
      exp_sv = (k % 4 == 0) && (k <= 128);
      if (exp_sv) begin
        ph  = ph + Base + 24'(mult[n / 8]) * Stp;
        smp = ph[23] ? -16'sd8192 : 16'sd8192;
        n++;
      end
      check({tag, "_sv"}, 32'(bus.sample_valid_out), 32'(exp_sv));
      check({tag, "_done"}, 32'(bus.done_out), 32'(k == 128));
      check({tag, "_err"}, 32'(bus.err_out), 32'd0);
      if (k <= 128) begin
        check({tag, "_busy"}, 32'(bus.busy_out), 32'd1);
        check({tag, "_ready"}, 32'(bus.ready_out), 32'd0);
        check({tag, "_sample"}, bus.sample_out, smp);
        if (exp_sv) check({tag, "_phase"}, 32'(dut.u_osc.phase_q), 32'(ph));
      end else begin
        check({tag, "_end_ready"}, 32'(bus.ready_out), 32'd1);
        check({tag, "_end_busy"}, 32'(bus.busy_out), 32'd0);
        check({tag, "_end_sample"}, bus.sample_out, 32'd0);
      end
      if (hold) bus.tone_ident_in = alt[k % 4];
    end
  endtask

  task automatic run_vec(input vec_t v);
    bus.tone_ident_in = v.code;
    bus.valid_in      = 1'b1;
    check({v.name, "_pre_ready"}, 32'(bus.ready_out), 32'd1);
    @(posedge clk_in);
    #1;
    bus.valid_in = 1'b0;
    if (!v.legal) begin
      check({v.name, "_err"}, 32'(bus.err_out), 32'd1);
      check({v.name, "_ready"}, 32'(bus.ready_out), 32'd1);
      check({v.name, "_busy"}, 32'(bus.busy_out), 32'd0);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk_in);
        #1;
        check_idle({v.name, "_after"});
      end
    end else begin
      check({v.name, "_acc_busy"}, 32'(bus.busy_out), 32'd1);
      check({v.name, "_acc_ready"}, 32'(bus.ready_out), 32'd0);
      play_body(v.name, v.mult, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{"rising",     3'b001, 1'b1, {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{"neutral",    3'b000, 1'b1, {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{"falling",    3'b100, 1'b1, {2'd0, 2'd1, 2'd2, 2'd3}};
    vecs[3] = '{"undulating", 3'b010, 1'b1, {2'd1, 2'd2, 2'd1, 2'd0}};
    vecs[4] = '{"illegal011", 3'b011, 1'b0, {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[5] = '{"illegal110", 3'b110, 1'b0, {2'd0, 2'd0, 2'd0, 2'd0}};

    bus.tone_ident_in = 3'b000;
    bus.valid_in      = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_idle("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check_idle("post_reset");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Asynchronous reset mid-play, right on a strobe cycle.
    bus.tone_ident_in = 3'b001;
    bus.valid_in      = 1'b1;
    @(posedge clk_in);
    #1;
    bus.valid_in = 1'b0;
    repeat (52) @(posedge clk_in);
    #1;
    check("midreset_pre_sv", 32'(bus.sample_valid_out), 32'd1);
    check("midreset_pre_busy", 32'(bus.busy_out), 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check_idle("midreset");
    check("midreset_phase", 32'(dut.u_osc.phase_q), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (6) begin
      @(posedge clk_in);
      #1;
      check_idle("midreset_after");
    end

    // valid held high with changing codes through a whole playback.
    bus.tone_ident_in = 3'b001;
    bus.valid_in      = 1'b1;
    @(posedge clk_in);
    #1;
    check("hold_acc_busy", 32'(bus.busy_out), 32'd1);
    play_body("hold", vecs[0].mult, 1'b1);
    bus.tone_ident_in = 3'b000;
    @(posedge clk_in);
    #1;
    bus.valid_in = 1'b0;
    check("hold2_acc_busy", 32'(bus.busy_out), 32'd1);
    check("hold2_acc_ready", 32'(bus.ready_out), 32'd0);
    play_body("hold2", vecs[1].mult, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
